cv32e40p_tmr_fault_ctrl: RTL
============================

Name: cv32e40p_tmr_fault_ctrl

Overview:
- Supervisory controller for the triplicated ALU and its majority voters.
- Watches per-replica disagreement flags on every completed ALU operation and keeps a saturating fault count per replica.
- Retires a replica that reaches a fault threshold, which puts the ALU into degraded two-replica mode.
- When no majority exists, stalls the EX stage, requests a re-execution, and escalates to a sticky fatal error after repeated failures.

Parameters:
- CNT_W, 4: width of each per-replica fault counter.
- FAULT_THRESH, 8: count value at which a replica is disabled; legal range 1..2^CNT_W-1.
- RETRY_WAIT, 2: stall cycles before a retry pulse; legal range 1..15.
- MAX_RETRY, 3: consecutive no-majority outcomes that escalate to FATAL; legal range 1..7.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  ALU operation in EX (ALU enable).
- ex_ready_i  in  1  EX result consumed this cycle.
- mismatch_i  in  3  bit k = replica k disagreed with the voted value, ORed over result, comparison and ready.
- no_majority_i  in  1  voters found no majority; in degraded mode, the two active replicas differ.
- clear_i  in  1  software clear: zero counters, re-enable replicas, leave FATAL.
- replica_en_o  out  3  voter mask; 0 = replica excluded.
- degraded_o  out  1  exactly one replica disabled.
- stall_o  out  1  hold EX stage (ANDed into ALU ready).
- retry_o  out  1  one-cycle pulse: re-issue current ALU operation.
- fatal_o  out  1  sticky unrecoverable TMR failure.
- irq_o  out  1  one-cycle pulse on replica retirement or entry into FATAL.
- fault_cnt_o  out  3*CNT_W  counters, replica 0 in the LSBs.

Behaviour:
- Reset values:
  - replica_en_o = 3'b111.
  - All counters = 0.
  - state = NORMAL.
  - stall_o, retry_o, fatal_o, irq_o, degraded_o = 0.
  - Internal retry counter and wait counter = 0.
- Sample event: valid_i & ex_ready_i, in state NORMAL only.
- Effective mismatch: em = mismatch_i & replica_en_o. Bits of disabled replicas are ignored.
- An event is a no-majority event if no_majority_i = 1, or if popcount(em) >= 2.
- NORMAL, on a no-majority event:
  - If retry_cnt+1 == MAX_RETRY: go to FATAL.
  - Otherwise: retry_cnt++, go to RETRY, stall_o = 1 starting the next cycle.
  - Counters are not updated.
- NORMAL, on any other event:
  - retry_cnt <= 0.
  - If em[k] = 1: cnt[k] increments, saturating at 2^CNT_W-1.
  - If the incremented count equals FAULT_THRESH:
    - If no replica is disabled yet: replica_en_o[k] <= 0, degraded_o <= 1, irq_o pulses 1 cycle.
    - If a replica is already disabled: go to FATAL.
- RETRY:
  - stall_o = 1; wait counter counts RETRY_WAIT cycles.
  - On the final wait cycle, retry_o = 1 for exactly 1 cycle. stall_o drops in the same cycle, then the state returns to NORMAL.
  - Sample events are ignored while in RETRY.
- FATAL:
  - fatal_o = 1 and stall_o = 0; the pipeline continues on the voted value.
  - irq_o pulses on the entry cycle only.
  - Only clear_i leaves FATAL.
- clear_i:
  - Highest priority after reset, in every state.
  - Next cycle: counters = 0, replica_en_o = 111, degraded_o = 0, retry_cnt = 0, state = NORMAL, stall_o = 0.
  - A sample event in the same cycle as clear_i is discarded.
- All outputs are registered; response latency is 1 cycle after the sample event.
- Reset asserted mid-RETRY or in FATAL returns every output to its reset value asynchronously.
- Counter saturation: a counter already at maximum holds its value.

Decomposition:
- Shared package (cv32e40p_pkg) holds:
  - Enum tmr_ctrl_state_e {TMR_NORMAL, TMR_RETRY, TMR_FATAL}.
  - Constant TMR_REPLICAS = 3.
- One natural sub-module: cv32e40p_tmr_fault_cnt, a saturating per-replica counter with increment, clear and threshold-hit output. It is instantiated 3x.

Test Plan:
- Reset release, then 10 events with mismatch_i = 000 -> counters 0, replica_en_o = 111, no stall or irq.
- 8 events with mismatch_i = 010 (FAULT_THRESH = 8) -> cnt1 = 8, replica_en_o = 101, degraded_o = 1, irq_o high exactly 1 cycle. A 9th 010 event leaves cnt1 at 8.
- One event with no_majority_i = 1 -> stall_o = 1 for 2 cycles, retry_o pulse in the 2nd cycle, then NORMAL. A clean event afterwards resets retry_cnt.
- Three consecutive no-majority events (each followed by a retry) -> 3rd event enters FATAL, fatal_o = 1, irq_o pulses. Then clear_i -> all state returns to reset values the next cycle.
- mismatch_i = 011 with no_majority_i = 0 -> treated as no majority: RETRY entered, no counter increments.
- Degraded mode with replica 1 disabled, then 8 events with mismatch_i = 001 -> FATAL on the 8th. mismatch_i = 010 events in degraded mode leave cnt1 unchanged. clear_i asserted in the same cycle as a sample event -> the event is discarded.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the TMR ALU supervisory logic.
package cv32e40p_pkg;

  // Number of ALU replicas behind the majority voters
  localparam int unsigned TMR_REPLICAS = 3;

  // Supervisory controller states
  typedef enum logic [1:0] {
    TMR_NORMAL = 2'd0,
    TMR_RETRY  = 2'd1,
    TMR_FATAL  = 2'd2
  } tmr_ctrl_state_e;

  // True when at least two of the (masked) replicas disagree with the vote,
  // i.e. the voted value cannot be trusted as a majority result.
  function automatic logic tmr_multi_fault(input logic [TMR_REPLICAS-1:0] em);
    return (em[0] & em[1]) | (em[0] & em[2]) | (em[1] & em[2]);
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_fault_cnt.sv
// Saturating fault counter for a single ALU replica. Reports a threshold hit
// combinationally in the cycle whose increment lands exactly on FAULT_THRESH.
module cv32e40p_tmr_fault_cnt #(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned FAULT_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] Thresh = CNT_W'(FAULT_THRESH);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             sat;

  assign sat = (cnt_q == CntMax);

  // A saturated counter never reports a new hit, so a replica cannot be
  // retired twice by a counter parked at its maximum.
  assign hit_o = inc_i & ~sat & ((cnt_q + CntOne) == Thresh);
  assign cnt_o = cnt_q;

  // Next count: clear wins, otherwise increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cv32e40p_tmr_fault_ctrl.sv
// Supervisory controller for the triplicated ALU. Tracks per-replica
// disagreements, retires a faulty replica (degraded two-replica mode),
// stalls and re-issues operations that have no majority, and escalates to a
// sticky fatal state after repeated failures. All outputs are registered.
module cv32e40p_tmr_fault_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned FAULT_THRESH = 8,
  parameter int unsigned RETRY_WAIT   = 2,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_i,
  input  logic                            ex_ready_i,
  input  logic [TMR_REPLICAS-1:0]         mismatch_i,
  input  logic                            no_majority_i,
  input  logic                            clear_i,
  output logic [TMR_REPLICAS-1:0]         replica_en_o,
  output logic                            degraded_o,
  output logic                            stall_o,
  output logic                            retry_o,
  output logic                            fatal_o,
  output logic                            irq_o,
  output logic [TMR_REPLICAS*CNT_W-1:0]   fault_cnt_o
);

  localparam logic [3:0] RetryWait = 4'(RETRY_WAIT);
  localparam logic [3:0] MaxRetry  = 4'(MAX_RETRY);

  tmr_ctrl_state_e state_d, state_q;

  logic [TMR_REPLICAS-1:0] replica_en_d, replica_en_q;
  logic                    degraded_d, degraded_q;
  logic                    stall_d, stall_q;
  logic                    retry_d, retry_q;
  logic                    fatal_d, fatal_q;
  logic                    irq_d, irq_q;
  logic [2:0]              retry_cnt_d, retry_cnt_q;
  logic [3:0]              wait_cnt_d, wait_cnt_q;

  logic [TMR_REPLICAS-1:0] em;
  logic [TMR_REPLICAS-1:0] cnt_inc;
  logic [TMR_REPLICAS-1:0] cnt_hit;
  logic                    multi;
  logic                    sample;
  logic                    nomaj_evt;
  logic                    clean_evt;
  logic                    last_retry;

  // Disagreements from retired replicas are meaningless and are masked off.
  // A sample coinciding with a software clear is dropped.
  assign em         = mismatch_i & replica_en_q;
  assign multi      = tmr_multi_fault(em);
  assign sample     = valid_i & ex_ready_i & ~clear_i & (state_q == TMR_NORMAL);
  assign nomaj_evt  = sample & (no_majority_i | multi);
  assign clean_evt  = sample & ~no_majority_i & ~multi;
  assign cnt_inc    = {TMR_REPLICAS{clean_evt}} & em;
  assign last_retry = (({1'b0, retry_cnt_q} + 4'd1) == MaxRetry);

  for (genvar k = 0; k < TMR_REPLICAS; k++) begin : g_cnt
    cv32e40p_tmr_fault_cnt #(
      .CNT_W        (CNT_W),
      .FAULT_THRESH (FAULT_THRESH)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (cnt_inc[k]),
      .clr_i (clear_i),
      .cnt_o (fault_cnt_o[k*CNT_W +: CNT_W]),
      .hit_o (cnt_hit[k])
    );
  end

  // Next-state and output decode; clear_i overrides everything at the end
  always_comb begin
    state_d      = state_q;
    replica_en_d = replica_en_q;
    degraded_d   = degraded_q;
    stall_d      = stall_q;
    retry_d      = 1'b0;
    fatal_d      = fatal_q;
    irq_d        = 1'b0;
    retry_cnt_d  = retry_cnt_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      TMR_NORMAL: begin
        if (nomaj_evt) begin
          if (last_retry) begin
            state_d = TMR_FATAL;
            fatal_d = 1'b1;
            irq_d   = 1'b1;
            stall_d = 1'b0;
          end else begin
            retry_cnt_d = retry_cnt_q + 3'd1;
            state_d     = TMR_RETRY;
            stall_d     = 1'b1;
            wait_cnt_d  = 4'd1;
            retry_d     = (RetryWait == 4'd1);
          end
        end else if (clean_evt) begin
          retry_cnt_d = '0;
          if (|cnt_hit) begin
            // At most one replica can hit here since a clean event has at
            // most one masked mismatch bit set.
            if (&replica_en_q) begin
              replica_en_d = replica_en_q & ~cnt_hit;
              degraded_d   = 1'b1;
              irq_d        = 1'b1;
            end else begin
              state_d = TMR_FATAL;
              fatal_d = 1'b1;
              irq_d   = 1'b1;
            end
          end
        end
      end

      TMR_RETRY: begin
        // The cycle presenting retry_o is the last stalled cycle
        if (retry_q) begin
          state_d    = TMR_NORMAL;
          stall_d    = 1'b0;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
          stall_d    = 1'b1;
          retry_d    = ((wait_cnt_q + 4'd1) == RetryWait);
        end
      end

      TMR_FATAL: begin
        stall_d = 1'b0;
      end

      default: begin
        state_d = TMR_NORMAL;
      end
    endcase

    if (clear_i) begin
      state_d      = TMR_NORMAL;
      replica_en_d = '1;
      degraded_d   = 1'b0;
      stall_d      = 1'b0;
      retry_d      = 1'b0;
      fatal_d      = 1'b0;
      irq_d        = 1'b0;
      retry_cnt_d  = '0;
      wait_cnt_d   = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TMR_NORMAL;
      replica_en_q <= '1;
      degraded_q   <= 1'b0;
      stall_q      <= 1'b0;
      retry_q      <= 1'b0;
      fatal_q      <= 1'b0;
      irq_q        <= 1'b0;
      retry_cnt_q  <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      replica_en_q <= replica_en_d;
      degraded_q   <= degraded_d;
      stall_q      <= stall_d;
      retry_q      <= retry_d;
      fatal_q      <= fatal_d;
      irq_q        <= irq_d;
      retry_cnt_q  <= retry_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign replica_en_o = replica_en_q;
  assign degraded_o   = degraded_q;
  assign stall_o      = stall_q;
  assign retry_o      = retry_q;
  assign fatal_o      = fatal_q;
  assign irq_o        = irq_q;

endmodule
